// File: rtl/demux_pkg.sv
// Shared definitions for the main-FIFO pop/demux controller.
package demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } demux_state_t;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
module skid_buf2
    import demux_pkg::*;
#(
    parameter int DATA_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rd,
    output logic [DATA_SIZE-1:0] hd,
    output logic [1:0]           occ,
    output logic                 ovf
);

    logic [DATA_SIZE-1:0] mem0;
    logic [DATA_SIZE-1:0] mem1;
    logic [1:0]           occ_q;
    logic                 do_rd;

    assign do_rd = rd && (occ_q != 2'd0);
    assign hd    = mem0;
    assign occ   = occ_q;
    assign ovf   = wr && !do_rd && (occ_q == 2'(SKID_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem0  <= '0;
            mem1  <= '0;
            occ_q <= 2'd0;
        end else begin
            case ({wr, do_rd})
                2'b10: begin
                    // A write into a full buffer is dropped; ovf reports it.
                    if (occ_q == 2'd0) begin
                        mem0  <= wdata;
                        occ_q <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        mem1  <= wdata;
                        occ_q <= 2'd2;
                    end
                end
                2'b01: begin
                    mem0  <= mem1;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        mem0 <= wdata;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/main_pop_demux.sv
// Pops the main FIFO under skid-buffer credit and steers each word to VC0/VC1
// by its destination bit, in strict order.
//
// state     | meaning
// ST_IDLE   | nothing buffered or in flight
// ST_ACTIVE | at least one word popped, buffered or being pushed
// ST_ERROR  | main FIFO error or skid overflow seen; frozen until reset
module main_pop_demux
    import demux_pkg::*;
#(
    parameter int DATA_SIZE  = 6,
    parameter int VC_SEL_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty_main,
    input  logic                 fifo_error_main,
    input  logic [DATA_SIZE-1:0] data_demux_vc,
    output logic                 pop_main,
    input  logic                 pause_vc0,
    input  logic                 pause_vc1,
    input  logic                 full_vc0,
    input  logic                 full_vc1,
    output logic                 push_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc0,
    output logic [DATA_SIZE-1:0] data_vc1,
    output logic                 idle,
    output logic                 demux_error
);

    demux_state_t         state;
    demux_state_t         state_next;
    logic                 inflight;
    logic [DATA_SIZE-1:0] hd;
    logic [1:0]           occ;
    logic                 ovf;
    logic                 sel;
    logic                 blocked;
    logic                 drain;
    logic [2:0]           pending;

    skid_buf2 #(.DATA_SIZE(DATA_SIZE)) u_skid (
        .clk   (clk),
        .reset (reset),
        .wr    (inflight),
        .wdata (data_demux_vc),
        .rd    (drain),
        .hd    (hd),
        .occ   (occ),
        .ovf   (ovf)
    );

    assign sel     = hd[VC_SEL_BIT];
    assign blocked = (sel == VC0) ? (pause_vc0 || full_vc0) : (pause_vc1 || full_vc1);
    assign drain   = (occ != 2'd0) && !blocked && (state != ST_ERROR);

    // Words that will be held after this edge if nothing new is popped.
    assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, drain};
    assign pop_main = !reset && enable && !fifo_empty_main && (state != ST_ERROR)
                      && (pending <= 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pop_main) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if ((pending == 3'd0) && !pop_main) state_next = ST_IDLE;
            end
            default: state_next = ST_ERROR;
        endcase
        if (fifo_error_main || ovf) state_next = ST_ERROR;
    end

    always_comb begin
        idle        = (state == ST_IDLE);
        demux_error = (state == ST_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            push_vc0 <= 1'b0;
            push_vc1 <= 1'b0;
            data_vc0 <= '0;
            data_vc1 <= '0;
        end else begin
            inflight <= pop_main;
            push_vc0 <= drain && (sel == VC0);
            push_vc1 <= drain && (sel == VC1);
            if (drain && (sel == VC0)) data_vc0 <= hd;
            if (drain && (sel == VC1)) data_vc1 <= hd;
        end
    end

endmodule

// File: tb/tb_main_pop_demux.sv
// Directed bench for main_pop_demux: a small main-FIFO model feeds the DUT and
// a negedge monitor logs pops and pushes for the per-scenario checks.
module tb_main_pop_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty_main;
    logic       fifo_error_main;
    logic [5:0] data_demux_vc = '0;
    logic       pop_main;
    logic       pause_vc0, pause_vc1, full_vc0, full_vc1;
    logic       push_vc0, push_vc1;
    logic [5:0] data_vc0, data_vc1;
    logic       idle, demux_error;

    int tests = 0;
    int fails = 0;

    logic [5:0] fmem [256];
    logic [7:0] wp = '0;
    logic [7:0] rp = '0;
    logic       flush = 1'b0;

    int         cyc = 0;
    int         npop = 0;
    int         npush = 0;
    int         pop_cyc [512];
    int         push_cyc [512];
    logic [5:0] push_word [512];
    logic       push_vc [512];

    main_pop_demux #(.DATA_SIZE(6), .VC_SEL_BIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .fifo_empty_main (fifo_empty_main),
        .fifo_error_main (fifo_error_main),
        .data_demux_vc   (data_demux_vc),
        .pop_main        (pop_main),
        .pause_vc0       (pause_vc0),
        .pause_vc1       (pause_vc1),
        .full_vc0        (full_vc0),
        .full_vc1        (full_vc1),
        .push_vc0        (push_vc0),
        .push_vc1        (push_vc1),
        .data_vc0        (data_vc0),
        .data_vc1        (data_vc1),
        .idle            (idle),
        .demux_error     (demux_error)
    );

    always #5 clk = ~clk;

    assign fifo_empty_main = (rp == wp);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) begin
            rp <= wp;
        end else if (pop_main) begin
            data_demux_vc <= fmem[rp];
            rp            <= rp + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (pop_main) begin
            pop_cyc[npop] = cyc;
            npop++;
        end
        if (push_vc0) begin
            push_cyc[npush]  = cyc;
            push_word[npush] = data_vc0;
            push_vc[npush]   = 1'b0;
            npush++;
        end
        if (push_vc1) begin
            push_cyc[npush]  = cyc;
            push_word[npush] = data_vc1;
            push_vc[npush]   = 1'b1;
            npush++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] w);
        fmem[wp] = w;
        wp = wp + 8'd1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        step();
        while (!(idle && fifo_empty_main) && n < max) begin
            step();
            n++;
        end
        tests++;
        if (n >= max) begin
            fails++;
            $display("FAIL %s drain timeout: idle=%0b empty=%0b after %0d cycles, required idle=1 empty=1",
                     name, idle, fifo_empty_main, n);
        end
        repeat (2) step();
    endtask

    task automatic reset_all();
        reset = 1'b1;
        enable = 1'b0;
        pause_vc0 = 1'b0;
        pause_vc1 = 1'b0;
        full_vc0 = 1'b0;
        full_vc1 = 1'b0;
        fifo_error_main = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_all();
        reset = 1'b1;
        load(6'h01);
        enable = 1'b1;
        #1;
        tests++; if (pop_main !== 1'b0) begin fails++; $display("FAIL reset_pop: got %0b want 0", pop_main); end
        tests++; if (push_vc0 !== 1'b0) begin fails++; $display("FAIL reset_push0: got %0b want 0", push_vc0); end
        tests++; if (push_vc1 !== 1'b0) begin fails++; $display("FAIL reset_push1: got %0b want 0", push_vc1); end
        tests++; if (data_vc0 !== 6'h00) begin fails++; $display("FAIL reset_data0: got %h want 00", data_vc0); end
        tests++; if (data_vc1 !== 6'h00) begin fails++; $display("FAIL reset_data1: got %h want 00", data_vc1); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %0b want 1", idle); end
        tests++; if (demux_error !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", demux_error); end
        reset_all();
    endtask

    task automatic test_streaming();
        logic [5:0] exp [8];
        int b0, b1;
        exp = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05, 6'h16, 6'h07, 6'h18};
        foreach (exp[i]) load(exp[i]);
        b0 = npop;
        b1 = npush;
        enable = 1'b1;
        wait_drain("stream", 60);
        enable = 1'b0;
        tests++; if (npop - b0 !== 8) begin fails++; $display("FAIL stream_pops: got %0d want 8", npop - b0); end
        tests++;
        if (pop_cyc[b0+7] - pop_cyc[b0] !== 7) begin
            fails++; $display("FAIL stream_rate: span %0d want 7", pop_cyc[b0+7] - pop_cyc[b0]);
        end
        tests++; if (npush - b1 !== 8) begin fails++; $display("FAIL stream_pushes: got %0d want 8", npush - b1); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (push_word[b1+k] !== exp[k] || push_vc[b1+k] !== exp[k][4]) begin
                fails++;
                $display("FAIL stream_word%0d: got %h on vc%0b want %h on vc%0b",
                         k, push_word[b1+k], push_vc[b1+k], exp[k], exp[k][4]);
            end
            tests++;
            if (push_cyc[b1+k] - pop_cyc[b0+k] !== 3) begin
                fails++;
                $display("FAIL stream_lat%0d: got %0d want 3", k, push_cyc[b1+k] - pop_cyc[b0+k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] exp [4];
        int b0, b1;
        exp = '{6'h05, 6'h06, 6'h17, 6'h08};
        pause_vc0 = 1'b1;
        foreach (exp[i]) load(exp[i]);
        b0 = npop;
        b1 = npush;
        enable = 1'b1;
        repeat (8) step();
        tests++; if (npop - b0 !== 2) begin fails++; $display("FAIL bp_held_pops: got %0d want 2", npop - b0); end
        tests++; if (npush - b1 !== 0) begin fails++; $display("FAIL bp_no_push: got %0d want 0", npush - b1); end
        tests++; if (pop_main !== 1'b0) begin fails++; $display("FAIL bp_pop_low: got %0b want 0", pop_main); end
        pause_vc0 = 1'b0;
        wait_drain("bp", 40);
        enable = 1'b0;
        tests++; if (npop - b0 !== 4) begin fails++; $display("FAIL bp_pops: got %0d want 4", npop - b0); end
        tests++; if (npush - b1 !== 4) begin fails++; $display("FAIL bp_pushes: got %0d want 4", npush - b1); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (push_word[b1+k] !== exp[k] || push_vc[b1+k] !== exp[k][4]) begin
                fails++;
                $display("FAIL bp_word%0d: got %h on vc%0b want %h on vc%0b",
                         k, push_word[b1+k], push_vc[b1+k], exp[k], exp[k][4]);
            end
        end
    endtask

    task automatic test_hol();
        int b1;
        pause_vc0 = 1'b1;
        load(6'h00);
        load(6'h10);
        b1 = npush;
        enable = 1'b1;
        repeat (8) step();
        tests++; if (npush - b1 !== 0) begin fails++; $display("FAIL hol_blocked: got %0d pushes want 0", npush - b1); end
        pause_vc0 = 1'b0;
        wait_drain("hol", 30);
        enable = 1'b0;
        tests++;
        if (push_word[b1] !== 6'h00 || push_vc[b1] !== 1'b0) begin
            fails++; $display("FAIL hol_first: got %h vc%0b want 00 vc0", push_word[b1], push_vc[b1]);
        end
        tests++;
        if (push_word[b1+1] !== 6'h10 || push_vc[b1+1] !== 1'b1) begin
            fails++; $display("FAIL hol_second: got %h vc%0b want 10 vc1", push_word[b1+1], push_vc[b1+1]);
        end
    endtask

    task automatic test_empty_enable();
        int b0, b1;
        load(6'h21);
        b0 = npop;
        b1 = npush;
        enable = 1'b1;
        wait_drain("single", 30);
        enable = 1'b0;
        tests++; if (npop - b0 !== 1) begin fails++; $display("FAIL single_pops: got %0d want 1", npop - b0); end
        tests++;
        if (npush - b1 !== 1 || push_word[b1] !== 6'h21) begin
            fails++; $display("FAIL single_push: got %0d pushes first %h want 1 of 21", npush - b1, push_word[b1]);
        end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle: got %0b want 1", idle); end

        for (int k = 1; k <= 8; k++) load(6'(k));
        b0 = npop;
        b1 = npush;
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        repeat (10) step();
        tests++; if (npop - b0 !== 3) begin fails++; $display("FAIL en_pops: got %0d want 3", npop - b0); end
        tests++; if (npush - b1 !== 3) begin fails++; $display("FAIL en_drained: got %0d want 3", npush - b1); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL en_idle: got %0b want 1", idle); end
        tests++; if (pop_main !== 1'b0) begin fails++; $display("FAIL en_pop_low: got %0b want 0", pop_main); end
        enable = 1'b1;
        wait_drain("en_resume", 40);
        enable = 1'b0;
        tests++; if (npush - b1 !== 8) begin fails++; $display("FAIL en_total: got %0d want 8", npush - b1); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (push_word[b1+k] !== 6'(k + 1)) begin
                fails++; $display("FAIL en_word%0d: got %h want %h", k, push_word[b1+k], 6'(k + 1));
            end
        end
    endtask

    task automatic test_error();
        int b0, b1;
        pause_vc0 = 1'b1;
        load(6'h01);
        load(6'h02);
        load(6'h03);
        enable = 1'b1;
        repeat (6) step();
        fifo_error_main = 1'b1;
        step();
        fifo_error_main = 1'b0;
        pause_vc0 = 1'b0;
        b0 = npop;
        b1 = npush;
        tests++; if (demux_error !== 1'b1) begin fails++; $display("FAIL err_flag: got %0b want 1", demux_error); end
        tests++; if (pop_main !== 1'b0) begin fails++; $display("FAIL err_pop: got %0b want 0", pop_main); end
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL err_idle: got %0b want 0", idle); end
        repeat (8) step();
        tests++; if (npop - b0 !== 0) begin fails++; $display("FAIL err_no_pops: got %0d want 0", npop - b0); end
        tests++; if (npush - b1 !== 0) begin fails++; $display("FAIL err_no_push: got %0d want 0", npush - b1); end
        tests++; if (demux_error !== 1'b1) begin fails++; $display("FAIL err_sticky: got %0b want 1", demux_error); end
        reset_all();
        tests++; if (demux_error !== 1'b0) begin fails++; $display("FAIL err_cleared: got %0b want 0", demux_error); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL err_reidle: got %0b want 1", idle); end
    endtask

    task automatic test_async_reset();
        int b0, b1;
        load(6'h0B);
        load(6'h1C);
        enable = 1'b1;
        wait_drain("pre_rst", 30);
        tests++; if (data_vc0 !== 6'h0B) begin fails++; $display("FAIL ar_pre0: got %h want 0b", data_vc0); end
        tests++; if (data_vc1 !== 6'h1C) begin fails++; $display("FAIL ar_pre1: got %h want 1c", data_vc1); end
        pause_vc0 = 1'b1;
        load(6'h02);
        load(6'h04);
        load(6'h06);
        repeat (6) step();
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL ar_busy: got %0b want 0", idle); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (data_vc0 !== 6'h00) begin fails++; $display("FAIL ar_data0: got %h want 00", data_vc0); end
        tests++; if (data_vc1 !== 6'h00) begin fails++; $display("FAIL ar_data1: got %h want 00", data_vc1); end
        tests++; if (push_vc0 !== 1'b0 || push_vc1 !== 1'b0) begin
            fails++; $display("FAIL ar_push: got %0b%0b want 00", push_vc0, push_vc1);
        end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL ar_idle: got %0b want 1", idle); end
        tests++; if (pop_main !== 1'b0) begin fails++; $display("FAIL ar_pop: got %0b want 0", pop_main); end
        tests++; if (demux_error !== 1'b0) begin fails++; $display("FAIL ar_err: got %0b want 0", demux_error); end
        enable = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        pause_vc0 = 1'b0;
        reset = 1'b0;
        step();
        load(6'h11);
        b0 = npop;
        b1 = npush;
        enable = 1'b1;
        wait_drain("post_rst", 30);
        enable = 1'b0;
        tests++; if (npop - b0 !== 1) begin fails++; $display("FAIL ar_post_pops: got %0d want 1", npop - b0); end
        tests++;
        if (npush - b1 !== 1 || push_word[b1] !== 6'h11 || push_vc[b1] !== 1'b1) begin
            fails++; $display("FAIL ar_post_push: got %0d pushes %h vc%0b want 1 of 11 vc1",
                              npush - b1, push_word[b1], push_vc[b1]);
        end
        tests++;
        if (push_cyc[b1] - pop_cyc[b0] !== 3) begin
            fails++; $display("FAIL ar_post_lat: got %0d want 3", push_cyc[b1] - pop_cyc[b0]);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_hol();
        test_empty_enable();
        test_error();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
